// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
package axi4_lite_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned STRB_W        = DATA_W / 8;
    localparam int unsigned IDX_W         = 4;
    localparam int unsigned NUM_REGS      = 16;
    localparam int unsigned NUM_USER_REGS = NUM_REGS - 1;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [15:0] ID_TAG      = 16'hA41E;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // One committed register write: target index, data and byte strobes.
    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_req_t;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Fifteen user registers with byte-strobe writes, plus the read mux
// that also serves the read-only ID word at index 15.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int unsigned id = 0
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              wr_en,
    input  wr_req_t                           wr_req,
    input  logic [IDX_W-1:0]                  rd_index,
    output logic [DATA_W-1:0]                 rd_data_c,
    output logic [NUM_USER_REGS*DATA_W-1:0]   reg_q
);

    logic [DATA_W-1:0] regs [NUM_USER_REGS];

    // Byte-lane merge; only lanes with their strobe set are touched.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < NUM_USER_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_USER_REGS; i++) begin
                if (wr_req.index == IDX_W'(i)) begin
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (wr_req.strb[b]) begin
                            regs[i][8*b +: 8] <= wr_req.data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        if (rd_index == IDX_W'(NUM_USER_REGS)) begin
            rd_data_c = {ID_TAG, 16'(id)};
        end else begin
            for (int unsigned i = 0; i < NUM_USER_REGS; i++) begin
                if (rd_index == IDX_W'(i)) begin
                    rd_data_c = regs[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_USER_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing a 16-word register window; independent
// write (AW/W/B) and read (AR/R) channel FSMs around a register file.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int unsigned id        = 0,
    parameter logic [31:0] base_addr = 32'h0000_0000
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [31:0]                     s_awaddr,
    input  logic [2:0]                      s_awprot,
    input  logic                            s_awvalid,
    output logic                            s_awready,
    input  logic [31:0]                     s_wdata,
    input  logic [3:0]                      s_wstrb,
    input  logic                            s_wvalid,
    output logic                            s_wready,
    output logic [1:0]                      s_bresp,
    output logic                            s_bvalid,
    input  logic                            s_bready,
    input  logic [31:0]                     s_araddr,
    input  logic [2:0]                      s_arprot,
    input  logic                            s_arvalid,
    output logic                            s_arready,
    output logic [31:0]                     s_rdata,
    output logic [1:0]                      s_rresp,
    output logic                            s_rvalid,
    input  logic                            s_rready,
    output logic [NUM_USER_REGS*DATA_W-1:0] reg_q,
    output logic                            wr_pulse,
    output logic [3:0]                      wr_index
);

    // Byte-lane offset and protection bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_awprot, s_arprot, s_awaddr[1:0], s_araddr[1:0]};

    w_state_t          w_state, w_state_nx;
    logic              aw_latched, aw_latched_nx;
    logic [29:0]       aw_addr, aw_addr_nx;
    logic              w_latched, w_latched_nx;
    logic [DATA_W-1:0] w_data, w_data_nx;
    logic [STRB_W-1:0] w_strb, w_strb_nx;
    logic              awready_nx, wready_nx, bvalid_nx, wr_pulse_nx;
    logic [1:0]        bresp_nx;
    logic [3:0]        wr_index_nx;
    logic              reg_wr_en_c;
    wr_req_t           reg_wr_req_c;
    logic              aw_in_range_c;

    r_state_t          r_state, r_state_nx;
    logic              arready_nx, rvalid_nx;
    logic [1:0]        rresp_nx;
    logic [DATA_W-1:0] rdata_nx;
    logic [DATA_W-1:0] rd_data_c;
    logic              ar_in_range_c;

    assign aw_in_range_c = (aw_addr[29:4] == base_addr[31:6]);
    assign ar_in_range_c = (s_araddr[31:6] == base_addr[31:6]);
    assign reg_wr_req_c  = '{index: aw_addr[3:0], data: w_data, strb: w_strb};

    axi4_lite_regfile #(
        .id        (id)
    ) u_regfile (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wr_en     (reg_wr_en_c),
        .wr_req    (reg_wr_req_c),
        .rd_index  (s_araddr[5:2]),
        .rd_data_c (rd_data_c),
        .reg_q     (reg_q)
    );

    // Write channel: collect AW and W in any order, commit one cycle later.
    always_comb begin
        w_state_nx    = w_state;
        aw_latched_nx = aw_latched;
        aw_addr_nx    = aw_addr;
        w_latched_nx  = w_latched;
        w_data_nx     = w_data;
        w_strb_nx     = w_strb;
        bvalid_nx     = s_bvalid;
        bresp_nx      = s_bresp;
        wr_pulse_nx   = 1'b0;
        wr_index_nx   = wr_index;
        reg_wr_en_c   = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_latched && w_latched) begin
                    w_state_nx    = W_RESP;
                    bvalid_nx     = 1'b1;
                    aw_latched_nx = 1'b0;
                    w_latched_nx  = 1'b0;
                    if (!aw_in_range_c) begin
                        bresp_nx = RESP_SLVERR;
                    end else begin
                        bresp_nx = RESP_OKAY;
                        if (aw_addr[3:0] != IDX_W'(NUM_USER_REGS)) begin
                            reg_wr_en_c = 1'b1;
                            wr_pulse_nx = 1'b1;
                            wr_index_nx = aw_addr[3:0];
                        end
                    end
                end else begin
                    if (s_awvalid && s_awready) begin
                        aw_latched_nx = 1'b1;
                        aw_addr_nx    = s_awaddr[31:2];
                    end
                    if (s_wvalid && s_wready) begin
                        w_latched_nx = 1'b1;
                        w_data_nx    = s_wdata;
                        w_strb_nx    = s_wstrb;
                    end
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_state_nx = W_IDLE;
                    bvalid_nx  = 1'b0;
                end
            end
            default: w_state_nx = W_IDLE;
        endcase
        awready_nx = (w_state_nx == W_IDLE) && !aw_latched_nx;
        wready_nx  = (w_state_nx == W_IDLE) && !w_latched_nx;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state    <= W_IDLE;
            aw_latched <= 1'b0;
            aw_addr    <= '0;
            w_latched  <= 1'b0;
            w_data     <= '0;
            w_strb     <= '0;
            s_awready  <= 1'b0;
            s_wready   <= 1'b0;
            s_bvalid   <= 1'b0;
            s_bresp    <= RESP_OKAY;
            wr_pulse   <= 1'b0;
            wr_index   <= '0;
        end else begin
            w_state    <= w_state_nx;
            aw_latched <= aw_latched_nx;
            aw_addr    <= aw_addr_nx;
            w_latched  <= w_latched_nx;
            w_data     <= w_data_nx;
            w_strb     <= w_strb_nx;
            s_awready  <= awready_nx;
            s_wready   <= wready_nx;
            s_bvalid   <= bvalid_nx;
            s_bresp    <= bresp_nx;
            wr_pulse   <= wr_pulse_nx;
            wr_index   <= wr_index_nx;
        end
    end

    // Read channel: data is captured at the AR handshake, before any same-edge write.
    always_comb begin
        r_state_nx = r_state;
        rvalid_nx  = s_rvalid;
        rdata_nx   = s_rdata;
        rresp_nx   = s_rresp;
        case (r_state)
            R_IDLE: begin
                if (s_arvalid && s_arready) begin
                    r_state_nx = R_DATA;
                    rvalid_nx  = 1'b1;
                    if (ar_in_range_c) begin
                        rdata_nx = rd_data_c;
                        rresp_nx = RESP_OKAY;
                    end else begin
                        rdata_nx = '0;
                        rresp_nx = RESP_SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    r_state_nx = R_IDLE;
                    rvalid_nx  = 1'b0;
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
        arready_nx = (r_state_nx == R_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= R_IDLE;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
        end else begin
            r_state   <= r_state_nx;
            s_arready <= arready_nx;
            s_rvalid  <= rvalid_nx;
            s_rdata   <= rdata_nx;
            s_rresp   <= rresp_nx;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs with hand-computed expectations.
module tb_axi4_lite_slave_regs;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [31:0]  s_awaddr;
    logic [2:0]   s_awprot;
    logic         s_awvalid;
    logic         s_awready;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         s_wvalid;
    logic         s_wready;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready;
    logic [31:0]  s_araddr;
    logic [2:0]   s_arprot;
    logic         s_arvalid;
    logic         s_arready;
    logic [31:0]  s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rvalid;
    logic         s_rready;
    logic [479:0] reg_q;
    logic         wr_pulse;
    logic [3:0]   wr_index;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;
    logic [31:0] model [15];

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (wr_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    axi4_lite_slave_regs #(
        .id        (3),
        .base_addr (32'h0000_0000)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_awaddr  (s_awaddr),
        .s_awprot  (s_awprot),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arprot  (s_arprot),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .reg_q     (reg_q),
        .wr_pulse  (wr_pulse),
        .wr_index  (wr_index)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output bit timeout);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0; timeout = 0;
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_fire = s_awvalid && s_awready;
            w_fire  = s_wvalid && s_wready;
            step(); cyc++;
            if (aw_fire) begin aw_done = 1; s_awvalid = 1'b0; end
            if (w_fire) begin w_done = 1; s_wvalid = 1'b0; end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        while (!s_bvalid && cyc < 40) begin step(); cyc++; end
        if (!s_bvalid) timeout = 1;
        resp = s_bresp;
        s_bready = 1'b1; step(); s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit timeout);
        bit fire;
        int cyc;
        cyc = 0; timeout = 0;
        s_araddr = addr; s_arvalid = 1'b1;
        do begin
            fire = s_arready;
            step(); cyc++;
        end while (!fire && cyc < 20);
        s_arvalid = 1'b0;
        while (!s_rvalid && cyc < 40) begin step(); cyc++; end
        if (!s_rvalid) timeout = 1;
        data = s_rdata; resp = s_rresp;
        s_rready = 1'b1; step(); s_rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) step();
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_valid_ready got=%b want=00000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        checks++;
        if ({s_bresp, s_rresp, s_rdata, wr_pulse, wr_index} !== 41'b0) begin
            failures++;
            $display("FAIL reset_data bresp=%b rresp=%b rdata=%h pulse=%b idx=%0d want all 0",
                     s_bresp, s_rresp, s_rdata, wr_pulse, wr_index);
        end
        checks++;
        if (reg_q !== 480'b0) begin
            failures++;
            $display("FAIL reset_regs got=%h want=0", reg_q);
        end
        aresetn = 1'b1;
        step();
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            failures++;
            $display("FAIL reset_release_ready got=%b want=111", {s_awready, s_wready, s_arready});
        end
    endtask

    task automatic test_write_read();
        logic [1:0] resp; logic [31:0] d; bit to;
        axi_write(32'h04, 32'hDEADBEEF, 4'hF, resp, to);
        model[1] = 32'hDEADBEEF;
        checks++;
        if (to || resp !== 2'b00) begin
            failures++;
            $display("FAIL wr_04_bresp got=%b timeout=%0d want=00", resp, to);
        end
        axi_read(32'h04, d, resp, to);
        checks++;
        if (to || d !== 32'hDEADBEEF || resp !== 2'b00) begin
            failures++;
            $display("FAIL rd_04 got=%h/%b timeout=%0d want=deadbeef/00", d, resp, to);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [31:0] d; bit to; int p0;
        axi_write(32'h08, 32'h12345678, 4'hF, resp, to);
        repeat (2) step();
        p0 = pulse_cnt;
        s_wdata = 32'h000000FF; s_wstrb = 4'b0001; s_wvalid = 1'b1;
        step(); s_wvalid = 1'b0;
        checks++;
        if ({s_awready, s_wready} !== 2'b10) begin
            failures++;
            $display("FAIL w_first_ready got=%b want=10", {s_awready, s_wready});
        end
        repeat (2) step();
        s_awaddr = 32'h08; s_awvalid = 1'b1;
        step(); s_awvalid = 1'b0;
        step();
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || wr_pulse !== 1'b1 || wr_index !== 4'd2) begin
            failures++;
            $display("FAIL w_first_commit bvalid=%b bresp=%b pulse=%b idx=%0d want 1/00/1/2",
                     s_bvalid, s_bresp, wr_pulse, wr_index);
        end
        s_bready = 1'b1; step(); s_bready = 1'b0;
        checks++;
        if ({s_awready, s_wready, s_bvalid, wr_pulse} !== 4'b1100) begin
            failures++;
            $display("FAIL after_b got=%b want=1100", {s_awready, s_wready, s_bvalid, wr_pulse});
        end
        repeat (2) step();
        model[2] = 32'h123456FF;
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            failures++;
            $display("FAIL pulse_count got=%0d want=1", pulse_cnt - p0);
        end
        axi_read(32'h08, d, resp, to);
        checks++;
        if (to || d !== 32'h123456FF || reg_q[2*32 +: 32] !== 32'h123456FF) begin
            failures++;
            $display("FAIL rd_08_merge got=%h reg_q=%h want=123456ff", d, reg_q[2*32 +: 32]);
        end
    endtask

    task automatic test_aw_first_strobes();
        logic [1:0] resp; logic [31:0] d; bit to;
        s_awaddr = 32'h00; s_awvalid = 1'b1;
        step(); s_awvalid = 1'b0;
        step();
        s_wdata = 32'hAABBCCDD; s_wstrb = 4'b1010; s_wvalid = 1'b1;
        step(); s_wvalid = 1'b0;
        while (!s_bvalid && checks < 1000) step();
        s_bready = 1'b1; step(); s_bready = 1'b0;
        model[0] = 32'hAA00CC00;
        axi_read(32'h00, d, resp, to);
        checks++;
        if (to || d !== 32'hAA00CC00) begin
            failures++;
            $display("FAIL aw_first_strb got=%h want=aa00cc00", d);
        end
        axi_write(32'h00, 32'hFFFFFFFF, 4'h0, resp, to);
        axi_read(32'h00, d, resp, to);
        checks++;
        if (to || d !== 32'hAA00CC00 || resp !== 2'b00) begin
            failures++;
            $display("FAIL strb_zero got=%h/%b want=aa00cc00/00", d, resp);
        end
    endtask

    task automatic test_reg15();
        logic [1:0] resp; logic [31:0] d; bit to; int p0;
        axi_read(32'h3C, d, resp, to);
        checks++;
        if (to || d !== 32'hA41E0003 || resp !== 2'b00) begin
            failures++;
            $display("FAIL rd_id got=%h/%b want=a41e0003/00", d, resp);
        end
        p0 = pulse_cnt;
        axi_write(32'h3C, 32'h11223344, 4'hF, resp, to);
        checks++;
        if (to || resp !== 2'b00 || pulse_cnt - p0 !== 0) begin
            failures++;
            $display("FAIL wr_id resp=%b pulses=%0d want=00/0", resp, pulse_cnt - p0);
        end
        axi_read(32'h3C, d, resp, to);
        checks++;
        if (to || d !== 32'hA41E0003) begin
            failures++;
            $display("FAIL rd_id_after got=%h want=a41e0003", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] d; bit to; logic [479:0] exp_q;
        axi_write(32'h40, 32'hFFFFFFFF, 4'hF, resp, to);
        checks++;
        if (to || resp !== 2'b10) begin
            failures++;
            $display("FAIL oor_bresp got=%b want=10", resp);
        end
        axi_read(32'h40, d, resp, to);
        checks++;
        if (to || d !== 32'h0 || resp !== 2'b10) begin
            failures++;
            $display("FAIL oor_read got=%h/%b want=0/10", d, resp);
        end
        for (int i = 0; i < 15; i++) exp_q[i*32 +: 32] = model[i];
        checks++;
        if (reg_q !== exp_q) begin
            failures++;
            $display("FAIL oor_regs_changed got=%h want=%h", reg_q, exp_q);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        s_awaddr = 32'h0C; s_wdata = 32'hA5A55A5A; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        step(); s_awvalid = 1'b0; s_wvalid = 1'b0;
        cyc = 0;
        while (!s_bvalid && cyc < 10) begin step(); cyc++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000) begin
                failures++;
                $display("FAIL b_hold cyc=%0d got=%b want=10000", i,
                         {s_bvalid, s_bresp, s_awready, s_wready});
            end
            step();
        end
        s_bready = 1'b1; step(); s_bready = 1'b0;
        model[3] = 32'hA5A55A5A;
        s_araddr = 32'h0C; s_arvalid = 1'b1;
        step(); s_arvalid = 1'b0;
        cyc = 0;
        while (!s_rvalid && cyc < 10) begin step(); cyc++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== 32'hA5A55A5A || s_rresp !== 2'b00 || s_arready !== 1'b0) begin
                failures++;
                $display("FAIL r_hold cyc=%0d rvalid=%b rdata=%h arready=%b want 1/a5a55a5a/0",
                         i, s_rvalid, s_rdata, s_arready);
            end
            step();
        end
        s_rready = 1'b1; step(); s_rready = 1'b0;
        checks++;
        if (s_arready !== 1'b1 || s_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL r_release arready=%b rvalid=%b want 1/0", s_arready, s_rvalid);
        end
    endtask

    task automatic test_read_during_commit();
        logic [1:0] resp; logic [31:0] d; bit to;
        axi_write(32'h10, 32'h11111111, 4'hF, resp, to);
        s_awaddr = 32'h10; s_wdata = 32'h22222222; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        step(); s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 32'h10; s_arvalid = 1'b1;
        step(); s_arvalid = 1'b0;
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h11111111 || s_bvalid !== 1'b1) begin
            failures++;
            $display("FAIL same_edge_read rvalid=%b rdata=%h bvalid=%b want 1/11111111/1",
                     s_rvalid, s_rdata, s_bvalid);
        end
        s_bready = 1'b1; s_rready = 1'b1; step(); s_bready = 1'b0; s_rready = 1'b0;
        model[4] = 32'h22222222;
        axi_read(32'h10, d, resp, to);
        checks++;
        if (to || d !== 32'h22222222) begin
            failures++;
            $display("FAIL post_commit_read got=%h want=22222222", d);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        s_awaddr = 32'h14; s_wdata = 32'h00005555; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        step(); s_awvalid = 1'b0; s_wvalid = 1'b0;
        cyc = 0;
        while (!s_bvalid && cyc < 10) begin step(); cyc++; end
        aresetn = 1'b0;
        step();
        checks++;
        if (s_bvalid !== 1'b0 || reg_q !== 480'b0 || s_awready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset bvalid=%b awready=%b regs_nonzero=%b want 0/0/0",
                     s_bvalid, s_awready, |reg_q);
        end
        aresetn = 1'b1;
        step();
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            failures++;
            $display("FAIL mid_reset_ready got=%b want=111", {s_awready, s_wready, s_arready});
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL stray_beat cyc=%0d bvalid=%b rvalid=%b want 0/0", i, s_bvalid, s_rvalid);
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        s_awaddr = '0; s_awprot = 3'b010; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arprot = 3'b101; s_arvalid = 1'b0; s_rready = 1'b0;
        for (int i = 0; i < 15; i++) model[i] = 32'h0;
        #1;
        test_reset();
        test_write_read();
        test_w_before_aw();
        test_aw_first_strobes();
        test_reg15();
        test_out_of_range();
        test_backpressure();
        test_read_during_commit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

Interface
REQ-001 SHALL have parameter id, default 0: BFM instance number; the value is readable in register 15.
REQ-002 SHALL have parameter base_addr, default 32'h0000_0000: byte base of the 64-byte register window.
REQ-003 SHALL have port aclk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports s_awaddr in 32, s_awprot in 3, s_awvalid in 1, s_awready out 1: write address channel.
REQ-006 SHALL have ports s_wdata in 32, s_wstrb in 4, s_wvalid in 1, s_wready out 1: write data channel.
REQ-007 SHALL have ports s_bresp out 2, s_bvalid out 1, s_bready in 1: write response channel.
REQ-008 SHALL have ports s_araddr in 32, s_arprot in 3, s_arvalid in 1, s_arready out 1: read address channel.
REQ-009 SHALL have ports s_rdata out 32, s_rresp out 2, s_rvalid out 1, s_rready in 1: read data channel.
REQ-010 SHALL have port reg_q, output, 15x32 flattened (480 bits): current contents of registers 0-14 for user logic.
REQ-011 SHALL have ports wr_pulse out 1 and wr_index out 4: a one-cycle strobe and the index of the register just written.

Function
REQ-012 SHALL decode the register index from addr[5:2]; addr[31:6] != base_addr[31:6] is out of range.
REQ-013 SHALL ignore addr[1:0] and the prot inputs.
REQ-014 SHALL run the write FSM with states W_IDLE, W_RESP.
REQ-015 In W_IDLE, awready SHALL be 1 while no address is latched, and wready SHALL be 1 while no data is latched.
REQ-016 AW and W SHALL be accepted in either order or in the same cycle.
REQ-017 In the cycle after both AW and W are latched, the write SHALL commit and the FSM SHALL go to W_RESP with bvalid=1 (one cycle of latency).
REQ-018 A write commit SHALL update only the bytes whose wstrb bit is set; wstrb=0 SHALL leave the register unchanged but still return OKAY.
REQ-019 SHALL assert wr_pulse=1 with wr_index for one cycle on each committed in-range write to registers 0-14.
REQ-020 A write to register 15 SHALL be ignored and SHALL return bresp OKAY.
REQ-021 A write out of range SHALL be ignored and SHALL return bresp SLVERR (2'b10).
REQ-022 bvalid and bresp SHALL hold until bready=1, then the FSM SHALL return to W_IDLE.
REQ-023 awready and wready SHALL be 0 throughout W_RESP and SHALL reassert on the cycle after the B handshake.
REQ-024 SHALL run the read FSM with states R_IDLE, R_DATA.
REQ-025 In R_IDLE, arready SHALL be 1; in the cycle after the AR handshake, rvalid SHALL be 1 with rdata/rresp registered.
REQ-026 rdata/rresp SHALL hold stable until rready=1; arready SHALL be 0 while in R_DATA.
REQ-027 Register 15 SHALL read {16'hA41E, id[15:0]}.
REQ-028 An out-of-range read SHALL return rdata 0 and rresp SLVERR.
REQ-029 Read and write FSMs SHALL run independently.
REQ-030 A read sampled in the same cycle as a write commit to the same register SHALL return the pre-write value.
REQ-031 No output SHALL depend combinationally on any input.

Reset
REQ-032 While aresetn=0 at a clock edge: all valid/ready outputs SHALL be 0, bresp, rresp and rdata SHALL be 0, wr_pulse SHALL be 0, wr_index SHALL be 0, and registers 0-14 SHALL be 0.
REQ-033 Reset SHALL return both FSMs to idle and discard any latched address or data.
REQ-034 Reset asserted mid-transaction SHALL abort it without producing a B or R beat.
REQ-035 awready, wready and arready SHALL be 1 on the first clock edge after reset deasserts.

Structure
REQ-036 Package axi4_lite_pkg SHALL hold the resp codes (OKAY=2'b00, SLVERR=2'b10), the FSM state enums, and the constant NUM_REGS=16.
REQ-037 The register array, byte-strobe merge and read mux SHALL be in sub-module axi4_lite_regfile.
REQ-038 The AXI channel FSMs SHALL remain in the top module.

Verification
REQ-039 Write 0x04 data 0xDEADBEEF wstrb 4'hF, with AW and W together -> bresp OKAY, and a read of 0x04 returns 0xDEADBEEF.
REQ-040 W given 3 cycles before AW, data 0x000000FF to 0x08 wstrb 4'b0001 over prior 0x12345678 -> 0x123456FF; wr_pulse fires once with wr_index 2.
REQ-041 Read 0x3C with id=3 -> rdata 0xA41E0003; write 0x3C -> OKAY and the value is unchanged.
REQ-042 Write or read at 0x40 -> SLVERR, rdata 0, and no register changes.
REQ-043 Hold bready/rready low for 5 cycles -> bvalid/rvalid and data remain stable, and the ready outputs stay 0.
REQ-044 Assert aresetn=0 while bvalid=1 -> next cycle bvalid=0, registers are 0, and there is no further B beat.
